// File: rtl/mips_mc_pkg.sv
// Shared constants and encodings for the multi-cycle MIPS datapath.
// Imported by the ALU and the datapath top.
package mips_mc_pkg;

    localparam logic [5:0] RTYPE_MUL = 6'b011000;
    localparam logic [5:0] MFHL      = 6'b010000;
    localparam logic [5:0] BEQ       = 6'b000100;
    localparam logic [5:0] ADDI      = 6'b001000;
    localparam logic [5:0] LW        = 6'b100011;
    localparam logic [5:0] J         = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_MFHI = 6'b010000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ADD2  = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] M2R_MDR  = 2'b00;
    localparam logic [1:0] M2R_HILO = 2'b01;
    localparam logic [1:0] M2R_ALU  = 2'b10;
    localparam logic [1:0] M2R_ZERO = 2'b11;

    localparam logic [1:0] PCS_ALUOUT = 2'b00;
    localparam logic [1:0] PCS_JUMP   = 2'b01;
    localparam logic [1:0] PCS_ALURES = 2'b10;
    localparam logic [1:0] PCS_RESET  = 2'b11;

    typedef enum logic [2:0] {
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_OR,
        FN_SLT,
        FN_MUL
    } alu_fn_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add/sub/and/or/slt and signed 32x32 multiply.
// Also produces the 64-bit product bus and the zero flag.
module mc_alu
    import mips_mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  aluOp,
    input  logic [5:0]  funct,
    output logic [31:0] res,
    output logic [63:0] prod,
    output logic        zero
);

    alu_fn_e     fn;
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] mul;

    // Pick the operation; unknown functs fall back to add
    always_comb begin
        fn = FN_ADD;
        case (aluOp)
            ALU_SUB: fn = FN_SUB;
            ALU_FUNCT: begin
                case (funct)
                    F_SUB:   fn = FN_SUB;
                    F_AND:   fn = FN_AND;
                    F_OR:    fn = FN_OR;
                    F_SLT:   fn = FN_SLT;
                    F_MULT:  fn = FN_MUL;
                    default: fn = FN_ADD;
                endcase
            end
            default: fn = FN_ADD;
        endcase
    end

    // Signed multiply: low 64 bits of the sign-extended operands
    always_comb begin
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        mul = sa * sb;
    end

    // Result, product bus and zero flag
    always_comb begin
        res = a + b;
        case (fn)
            FN_SUB:  res = a - b;
            FN_AND:  res = a & b;
            FN_OR:   res = a | b;
            FN_SLT:  res = {31'd0, $signed(a) < $signed(b)};
            FN_MUL:  res = mul[31:0];
            default: res = a + b;
        endcase
        prod = (fn == FN_MUL) ? mul : {{32{res[31]}}, res};
        zero = (res == 32'd0);
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath driven by an external control FSM.
// Holds PC, IR, MDR, A, B, ALUOut, PROD, HI, LO and the register file.
module mc_datapath
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NREGS        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IorD,
    input  logic        memRead,
    input  logic        IRWrite,
    input  logic        regDest,
    input  logic        regWrite,
    input  logic        aluSrcA,
    input  logic [1:0]  aluSrcB,
    input  logic [1:0]  aluOp,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic [1:0]  memToReg,
    input  logic [1:0]  pcSrc,
    input  logic        pcWrite,
    input  logic        branch,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] aluout;
    logic [63:0] prod_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rf [NREGS];

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_reg;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [31:0] imm;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] wr_data;
    logic [31:0] pc_next;
    logic [31:0] alu_res;
    logic [63:0] alu_prod;
    logic        zero;
    logic        pc_en;

    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign imm      = sext16(ir[15:0]);
    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign pc       = pc_q;
    assign mem_re   = memRead;
    assign mem_addr = IorD ? aluout : pc_q;
    assign pc_en    = pcWrite | (branch & zero);

    mc_alu u_alu (
        .a     (src_a),
        .b     (src_b),
        .aluOp (aluOp),
        .funct (funct),
        .res   (alu_res),
        .prod  (alu_prod),
        .zero  (zero)
    );

    // Register-file reads with R0 hardwired to zero
    always_comb begin
        rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
        rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];
    end

    // Operand, write-back and next-PC muxes
    always_comb begin
        src_a  = aluSrcA ? a_q : pc_q;
        src_b  = b_q;
        wr_reg = regDest ? ir[15:11] : rt;
        case (aluSrcB)
            SRCB_FOUR:  src_b = 32'd4;
            SRCB_IMM:   src_b = imm;
            SRCB_IMMSH: src_b = {imm[29:0], 2'b00};
            default:    src_b = b_q;
        endcase
        case (memToReg)
            M2R_HILO: wr_data = (funct == F_MFHI) ? hi : lo;
            M2R_ALU:  wr_data = aluout;
            M2R_ZERO: wr_data = 32'd0;
            default:  wr_data = mdr;
        endcase
        case (pcSrc)
            PCS_JUMP:   pc_next = {pc_q[31:28], ir[25:0], 2'b00};
            PCS_ALURES: pc_next = alu_res;
            PCS_RESET:  pc_next = RESET_VECTOR;
            default:    pc_next = aluout;
        endcase
    end

    // Program counter: one write from the mux on pcWrite or taken branch
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_VECTOR;
        else if (pc_en) pc_q <= pc_next;
    end

    // Instruction register loads only on fetch
    always_ff @(posedge clk) begin
        if (reset) ir <= '0;
        else if (IRWrite) ir <= mem_rdata;
    end

    // Free-running inter-cycle registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mdr    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            aluout <= '0;
            prod_q <= '0;
        end else begin
            mdr    <= mem_rdata;
            a_q    <= rd_a;
            b_q    <= rd_b;
            aluout <= alu_res;
            prod_q <= alu_prod;
        end
    end

    // HI/LO capture the latched product halves
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hiWrite) hi <= prod_q[63:32];
            if (loWrite) lo <= prod_q[31:0];
        end
    end

    // Register file write port; R0 writes are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (regWrite && (wr_reg != 5'd0)) begin
            rf[wr_reg] <= wr_data;
        end
    end

endmodule
